rtc_stopwatch_core: RTL

Stopwatch timekeeping stage that sits directly upstream of rtc_adapter. It counts elapsed time as MM:SS.hh in six BCD digits, under start/stop, lap and clear controls. Each digit is encoded to an active-low seven-segment byte, and the six registered bytes drive rtc_adapter's i_segout1..i_segout6 directly.

---
 rtl/rtc_stopwatch_core_pkg.sv | 46 ++++
 rtl/rtc_stopwatch_core_if.sv | 28 ++
 rtl/rtc_stopwatch_core_seg_encoder.sv | 17 +
 rtl/rtc_stopwatch_core.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/rtc_stopwatch_core_pkg.sv
// Shared types and constants for the stopwatch core: FSM states, BCD count
// layout, seven-segment code table and the BCD count increment.
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Digit 0 is hundredths-ones, digit 5 is minutes-tens.
    typedef bcd_t [5:0] count_t;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_DP_MASK = 8'h7F;
    localparam logic [7:0] SEG_BLANK   = 8'hFF;

    localparam bcd_t   DIGIT_MAX [0:5] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5};
    localparam count_t CNT_LAST        = 24'h595999;

    // Ripple-carry BCD increment; 59:59.99 rolls over to 00:00.00.
    function automatic count_t count_inc(input count_t c);
        count_t r;
        logic   carry;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (r[i] == DIGIT_MAX[i]) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = r[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_stopwatch_core_if.sv
// Control and display bundle between the stopwatch core and its surroundings.
interface rtc_stopwatch_core_if;

    logic       i_start_stop;
    logic       i_lap;
    logic       i_clear;
    logic [7:0] o_segout1;
    logic [7:0] o_segout2;
    logic [7:0] o_segout3;
    logic [7:0] o_segout4;
    logic [7:0] o_segout5;
    logic [7:0] o_segout6;
    logic       o_running;
    logic       o_wrapped;

    modport master (
        output i_start_stop, i_lap, i_clear,
        input  o_segout1, o_segout2, o_segout3, o_segout4, o_segout5, o_segout6,
        input  o_running, o_wrapped
    );

    modport slave (
        input  i_start_stop, i_lap, i_clear,
        output o_segout1, o_segout2, o_segout3, o_segout4, o_segout5, o_segout6,
        output o_running, o_wrapped
    );

endinterface

// File: rtl/rtc_stopwatch_core_seg_encoder.sv
// BCD digit to active-low seven-segment byte; non-decimal codes blank the digit.
module rtc_seg_encoder
    import rtc_pkg::*;
(
    input  bcd_t       digit,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = dp ? (SEG_DIGIT[digit] & SEG_DP_MASK) : SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/rtc_stopwatch_core.sv
// Stopwatch core: synchronised controls, run/stop/lap FSM, prescaled MM:SS.hh
// BCD count and registered seven-segment outputs.
//
// state | meaning
// IDLE  | count zeroed, waiting for start
// RUN   | counting, display shows live count
// STOP  | count frozen, clear allowed
// LAP   | counting, display shows latched count
module rtc_stopwatch_core
    import rtc_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100
) (
    input  logic                i_sclk,
    input  logic                i_reset_n,
    rtc_stopwatch_core_if.slave bus
);

    localparam int             DIV      = CLK_HZ / TICK_HZ;
    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_TC = PW'(DIV - 1);

    logic [2:0]    sync1, sync2, sync3, pulse;
    logic          ss_p, lap_p, clr_p;
    state_t        state, state_nxt;
    logic          clr_go, lap_cap, running, tick;
    logic [PW-1:0] presc;
    count_t        cnt, latch, disp;
    logic          wrapped;
    logic [7:0]    seg_enc [6];
    logic [7:0]    seg_q   [6];

    // Bit order in the control vectors: {clear, lap, start_stop}.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            pulse <= '0;
        end else begin
            sync1 <= {bus.i_clear, bus.i_lap, bus.i_start_stop};
            sync2 <= sync1;
            sync3 <= sync2;
            pulse <= sync2 & ~sync3;
        end
    end

    assign ss_p  = pulse[0];
    assign lap_p = pulse[1];
    assign clr_p = pulse[2];

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_go    = 1'b0;
        lap_cap   = 1'b0;
        case (state)
            IDLE: if (ss_p) state_nxt = RUN;
            RUN: begin
                if (ss_p) begin
                    state_nxt = STOP;
                end else if (lap_p) begin
                    state_nxt = LAP;
                    lap_cap   = 1'b1;
                end
            end
            LAP: begin
                if (ss_p)       state_nxt = STOP;
                else if (lap_p) state_nxt = RUN;
            end
            STOP: begin
                if (clr_p) begin
                    state_nxt = IDLE;
                    clr_go    = 1'b1;
                end else if (ss_p) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign running = (state == RUN) || (state == LAP);
    assign tick    = running && (presc == PRESC_TC);

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n)                     presc <= '0;
        else if (clr_go || state == IDLE)   presc <= '0;
        else if (running)                   presc <= tick ? '0 : presc + 1'b1;
    end

    // A tick on the same edge as RUN->STOP still advances the count.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt     <= '0;
            wrapped <= 1'b0;
        end else if (clr_go) begin
            cnt     <= '0;
            wrapped <= 1'b0;
        end else if (tick) begin
            cnt <= count_inc(cnt);
            if (cnt == CNT_LAST) wrapped <= 1'b1;
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n)   latch <= '0;
        else if (lap_cap) latch <= cnt;
    end

    assign disp = (state == LAP) ? latch : cnt;

    for (genvar g = 0; g < 6; g++) begin : g_digit
        localparam logic       DP     = (g == 2) || (g == 4);
        localparam logic [7:0] SEG_RST = DP ? (SEG_DIGIT[0] & SEG_DP_MASK) : SEG_DIGIT[0];

        rtc_seg_encoder u_enc (
            .digit (disp[g]),
            .dp    (DP),
            .seg   (seg_enc[g])
        );

        always_ff @(posedge i_sclk or negedge i_reset_n) begin
            if (!i_reset_n) seg_q[g] <= SEG_RST;
            else            seg_q[g] <= seg_enc[g];
        end
    end

    assign bus.o_segout1 = seg_q[0];
    assign bus.o_segout2 = seg_q[1];
    assign bus.o_segout3 = seg_q[2];
    assign bus.o_segout4 = seg_q[3];
    assign bus.o_segout5 = seg_q[4];
    assign bus.o_segout6 = seg_q[5];
    assign bus.o_running = running;
    assign bus.o_wrapped = wrapped;

endmodule
